// File: rtl/vco_sense_counter.sv
// Multi-channel VCO edge counter: gated counting, latched parallel result and stall-able serial readout.
// Optional build macro VCO_SENSE_AVG_EN averages four back-to-back count windows per measurement.
module vco_sense_counter #(
  parameter int NCH           = 4,
  parameter int CW            = 12,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              cont,
  input  logic [NCH-1:0]    vco_in,
  input  logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              sr_out,
  output logic [NCH*CW-1:0] data_o,
  output logic [NCH-1:0]    ovf_o
);

  localparam int TOT  = NCH * CW;
  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(TOT + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_COUNT  = 3'd2,
    S_LATCH  = 3'd3,
    S_SHIFT  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NCH-1:0]          r_sync1, r_sync2, r_sync3;
  logic [NCH-1:0]          w_edge;
  logic [TW-1:0]           r_timer;
  logic [BW-1:0]           r_bitcnt;
  logic [NCH-1:0][CW-1:0]  r_cnt;
  logic [NCH-1:0][CW-1:0]  w_cnt_nxt;
  logic [NCH-1:0][CW-1:0]  w_result;
  logic [NCH-1:0]          r_ovf_acc;
  logic [NCH-1:0]          w_ovf_nxt;
  logic [TOT-1:0]          r_sr;
  logic [NCH*CW-1:0]       r_data;
  logic [NCH-1:0]          r_ovf;
  logic                    r_done;
  logic                    w_settle_end, w_win_end, w_meas_end, w_last_bit;

`ifdef VCO_SENSE_AVG_EN
  logic [1:0]              r_win;
  logic [NCH-1:0][CW+1:0]  r_acc;
  assign w_meas_end = w_win_end && (r_win == 2'd3);
`else
  assign w_meas_end = w_win_end;
`endif

  assign w_edge       = r_sync2 & ~r_sync3;
  assign w_settle_end = (r_state == S_SETTLE) && (r_timer == TW'(SETTLE_CYCLES - 1));
  assign w_win_end    = (r_state == S_COUNT) && (r_timer == TW'(GATE_CYCLES - 1));
  assign w_last_bit   = (r_state == S_SHIFT) && shift_en && (r_bitcnt == BW'(TOT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE; else w_next = S_IDLE;
      S_SETTLE: if (w_settle_end) w_next = S_COUNT; else w_next = S_SETTLE;
      S_COUNT:  if (w_meas_end) w_next = S_LATCH; else w_next = S_COUNT;
      S_LATCH:  w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) w_next = cont ? S_SETTLE : S_IDLE;
        else            w_next = S_SHIFT;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state != S_IDLE);
    sr_out = (r_state == S_SHIFT) ? r_sr[TOT-1] : 1'b0;
  end

  assign done   = r_done;
  assign data_o = r_data;
  assign ovf_o  = r_ovf;

  // Two synchroniser flops plus one history flop for rising-edge detection.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= {NCH{1'b0}};
      r_sync2 <= {NCH{1'b0}};
      r_sync3 <= {NCH{1'b0}};
    end else begin
      r_sync1 <= vco_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                       r_timer <= {TW{1'b0}};
    else if (w_settle_end || w_win_end) r_timer <= {TW{1'b0}};
    else if (r_state == S_SETTLE || r_state == S_COUNT) r_timer <= r_timer + TW'(1);
    else                                r_timer <= {TW{1'b0}};
  end

  // Saturating increment; an edge arriving at full scale only raises the flag.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf_acc;
    for (int k = 0; k < NCH; k++) begin
      if (w_edge[k]) begin
        if (r_cnt[k] == CMAX) w_ovf_nxt[k] = 1'b1;
        else                  w_cnt_nxt[k] = r_cnt[k] + CW'(1);
      end else begin
        w_cnt_nxt[k] = r_cnt[k];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt     <= '0;
      r_ovf_acc <= {NCH{1'b0}};
    end else if (r_state == S_SETTLE) begin
      r_cnt     <= '0;
      r_ovf_acc <= {NCH{1'b0}};
    end else if (r_state == S_COUNT) begin
      r_ovf_acc <= w_ovf_nxt;
`ifdef VCO_SENSE_AVG_EN
      r_cnt     <= w_win_end ? '0 : w_cnt_nxt;
`else
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

`ifdef VCO_SENSE_AVG_EN
  // Each window's final count, including an edge on its last cycle, folds into the accumulator.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_win <= 2'd0;
      r_acc <= '0;
    end else if (r_state == S_SETTLE) begin
      r_win <= 2'd0;
      r_acc <= '0;
    end else if (w_win_end) begin
      r_win <= r_win + 2'd1;
      for (int k = 0; k < NCH; k++) r_acc[k] <= r_acc[k] + {2'b00, w_cnt_nxt[k]};
    end
  end
`endif

  always_comb begin
    w_result = '0;
    for (int k = 0; k < NCH; k++) begin
`ifdef VCO_SENSE_AVG_EN
      w_result[k] = r_acc[k][CW+1:2];
`else
      w_result[k] = r_cnt[k];
`endif
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_data <= {(NCH*CW){1'b0}};
      r_ovf  <= {NCH{1'b0}};
    end else if (r_state == S_LATCH) begin
      r_data <= w_result;
      r_ovf  <= r_ovf_acc;
    end
  end

  // Channel NCH-1 sits in the top bits, so shifting left gives MSB-first, highest channel first.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sr     <= {TOT{1'b0}};
      r_bitcnt <= {BW{1'b0}};
    end else if (r_state == S_LATCH) begin
      r_sr     <= w_result;
      r_bitcnt <= {BW{1'b0}};
    end else if (r_state == S_SHIFT && shift_en) begin
      r_sr     <= {r_sr[TOT-2:0], 1'b0};
      r_bitcnt <= r_bitcnt + BW'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_done <= 1'b0;
    else          r_done <= w_last_bit;
  end

endmodule

// File: tb/tb_vco_sense_counter.sv
// Randomised bench for vco_sense_counter: a wide instance for counting/readout and a narrow one for saturation.
module tb_vco_sense_counter;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int G   = 100;
  localparam int S   = 3;
  localparam int TOT = NCH * CW;
  localparam int SCW = 4;

  logic clk = 1'b0;
  logic rst, start, cont, shift_en, busy, done, sr_out;
  logic [NCH-1:0]    vco, ovf;
  logic [TOT-1:0]    data;
  logic start_s, cont_s, shift_s, busy_s, done_s, sr_s;
  logic [0:0]        vco_s, ovf_s;
  logic [SCW-1:0]    data_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done = -1;
  int rem [0:1];
  logic [2:0] lvl;
  logic [2:0] vh [0:4095];
  bit quiet;
  logic [TOT-1:0] prev_data;
  logic [NCH-1:0] prev_ovf;

  vco_sense_counter #(.NCH(NCH), .CW(CW), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .cont(cont), .vco_in(vco),
    .shift_en(shift_en), .busy(busy), .done(done), .sr_out(sr_out), .data_o(data), .ovf_o(ovf));

  vco_sense_counter #(.NCH(1), .CW(SCW), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) u_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_s), .cont(cont_s), .vco_in(vco_s),
    .shift_en(shift_s), .busy(busy_s), .done(done_s), .sr_out(sr_s), .data_o(data_s), .ovf_o(ovf_s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive the next VCO levels and record them.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      if (quiet) begin
        lvl[ch] = 1'b0;
        rem[ch] = 0;
      end else begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = int'($urandom_range(2, 6));
        end
        rem[ch]--;
      end
    end
    lvl[2] = ((cyc % 4) < 2);
    vco    = lvl[1:0];
    vco_s  = lvl[2:2];
    if (cyc < 4096) vh[cyc] = lvl;
  endtask

  // A VCO level first seen in cycle r (low in r-1) is counted if cycle r+2 lies inside the window.
  function automatic int pulses(input int ch, input int c0);
    int n = 0;
    for (int m = c0; m < c0 + G; m++)
      if (m >= 3 && vh[m-2][ch] == 1'b1 && vh[m-3][ch] == 1'b0) n++;
    return n;
  endfunction

  function automatic int satv(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic run_meas(input bit do_start, input bit cont_v, input bit stall, input bit chk_gap);
    int s, c0, n0, n1, ns, idx, guard;
    logic [CW-1:0]  e0, e1;
    logic [TOT-1:0] expd;
    logic [NCH-1:0] expo;
    logic [SCW-1:0] es;
    bit se;
    if (do_start) begin
      start = 1'b1; start_s = 1'b1; s = cyc;
    end else begin
      s = last_done - 1;
    end
    cont = 1'($urandom_range(0, 1));
    c0 = s + S + 1;
    while (cyc < s + S + G + 2) begin
      step();
      start    = 1'($urandom_range(0, 1));
      start_s  = 1'b0;
      cont     = 1'($urandom_range(0, 1));
      shift_en = 1'($urandom_range(0, 1));
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_quiet", 32'(done), 32'd0);
      if (do_start) chk("sat_busy", 32'(busy_s), 32'd1);
      if (cyc == s + S + G + 1) begin
        chk("data_hold", 32'(data), 32'(prev_data));
        chk("ovf_hold", 32'(ovf), 32'(prev_ovf));
      end
    end
    n0 = pulses(0, c0);
    n1 = pulses(1, c0);
    e0 = CW'(satv(n0, CW));
    e1 = CW'(satv(n1, CW));
    expd = {e1, e0};
    expo = {n1 > 255, n0 > 255};
    chk("data_o", 32'(data), 32'(expd));
    chk("ovf_o", 32'(ovf), 32'(expo));
    prev_data = expd;
    prev_ovf  = expo;
    if (do_start) begin
      ns = pulses(2, c0);
      es = SCW'(satv(ns, SCW));
      chk("sat_data", 32'(data_s), 32'(es));
      chk("sat_ovf", 32'(ovf_s), (ns > 15) ? 32'd1 : 32'd0);
      chk("sat_msb", 32'(sr_s), 32'(es[SCW-1]));
    end
    idx = 0;
    guard = 0;
    while (idx < TOT && guard < 300) begin
      chk("sr_bit", 32'(sr_out), 32'(expd[TOT-1-idx]));
      chk("done_early", 32'(done), 32'd0);
      if (do_start && cyc == s + S + G + 6) chk("sat_done", 32'(done_s), 32'd1);
      se = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      shift_en = se;
      cont  = (se && idx == TOT - 1) ? cont_v : 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if (se) idx++;
      guard++;
      step();
    end
    start = 1'b0;
    shift_en = 1'b0;
    chk("shift_count", 32'(idx), 32'(TOT));
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'(cont_v));
    chk("sr_outside", 32'(sr_out), 32'd0);
    if (chk_gap) chk("done_spacing", 32'(cyc - last_done), 32'(S + G + 1 + TOT));
    last_done = cyc;
    step();
    chk("done_once", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'(cont_v));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) vh[i] = 3'b000;
    rst = 1'b1; start = 1'b0; cont = 1'b0; shift_en = 1'b0; vco = '0;
    start_s = 1'b0; cont_s = 1'b0; shift_s = 1'b1; vco_s = '0;
    quiet = 1'b0; lvl = 3'b000; rem[0] = 0; rem[1] = 0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sr", 32'(sr_out), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_sat_busy", 32'(busy_s), 32'd0);
    rst = 1'b0;
    prev_data = '0;
    prev_ovf  = '0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    repeat (3) run_meas(1'b1, 1'b0, 1'b1, 1'b0);
    run_meas(1'b1, 1'b0, 1'b0, 1'b0);

    // Abort 50 cycles into the count window.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (S + 50) step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_data", 32'(data), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_sr", 32'(sr_out), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    quiet = 1'b1;
    prev_data = '0;
    prev_ovf  = '0;
    repeat (3) step();
    chk("abort_idle", 32'(busy), 32'd0);
    run_meas(1'b1, 1'b0, 1'b0, 1'b0);
    quiet = 1'b0;

    run_meas(1'b1, 1'b1, 1'b0, 1'b0);
    run_meas(1'b0, 1'b1, 1'b0, 1'b1);
    run_meas(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
